// File: rtl/muldiv.sv
// muldiv: iterative signed/unsigned multiply-divide unit producing a HI/LO pair with busy/done handshake
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] oprand1_i,
  input  logic [WIDTH-1:0] oprand2_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0] b_reg, a_mag, b_mag, quo, rem;
  logic [WIDTH:0] sum, trial;
  logic is_div, is_zero, neg_q, neg_r, a_neg, b_neg, div_zero, accept, wr;
  always_comb begin
    a_neg = !op_i[0] && oprand1_i[WIDTH-1];
    b_neg = !op_i[0] && oprand2_i[WIDTH-1];
    a_mag = a_neg ? -oprand1_i : oprand1_i;
    b_mag = b_neg ? -oprand2_i : oprand2_i;
    div_zero = op_i[1] && oprand2_i == '0;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_reg};
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? ((start_i && !cancel_i) ? (div_zero ? FIX : CALC) : IDLE)
              : cancel_i ? IDLE
              : (state == CALC) ? ((cnt == CW'(WIDTH-1)) ? FIX : CALC)
              : IDLE;
  always_comb begin
    busy_o = state != IDLE;
    accept = state == IDLE && start_i && !cancel_i;
    wr = state == FIX && !cancel_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      b_reg <= '0;
      is_div <= 1'b0;
      is_zero <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done_o <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      done_o <= wr;
      if (accept) begin
        cnt <= '0;
        acc <= {{WIDTH{1'b0}}, op_i[1] ? (div_zero ? oprand1_i : a_mag) : b_mag};
        b_reg <= op_i[1] ? b_mag : a_mag;
        is_div <= op_i[1];
        is_zero <= div_zero;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= !is_div ? {sum, acc[WIDTH-1:1]}
             : trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
             : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
      if (wr)
        {hi_o, lo_o} <= is_zero ? {acc[WIDTH-1:0], {WIDTH{1'b1}}} : is_div ? {rem, quo} : prod;
    end
  end
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed self-checking bench for muldiv
module tb_muldiv;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] op_i = '0;
  logic [31:0] oprand1_i = '0;
  logic [31:0] oprand2_i = '0;
  logic cancel_i = 1'b0;
  logic busy_o, done_o;
  logic [31:0] hi_o, lo_o;
  int n_checks = 0;
  int n_pass = 0;
  int lat, busy_cnt, done_cnt;
  muldiv #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .op_i(op_i),
    .oprand1_i(oprand1_i),
    .oprand2_i(oprand2_i),
    .cancel_i(cancel_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .hi_o(hi_o),
    .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i = op;
    oprand1_i = a;
    oprand2_i = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask
  task automatic wait_done(input string tag, output int l, output int bc);
    l = 1;
    bc = 0;
    while (!done_o && l < 100) begin
      bc += int'(busy_o);
      @(negedge clk);
      l++;
    end
    check({tag, " done"}, done_o, 1);
    check({tag, " busy at done"}, busy_o, 0);
  endtask
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi_exp, input logic [31:0] lo_exp, input int lat_exp);
    launch(op, a, b);
    wait_done(tag, lat, busy_cnt);
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " hi"}, hi_o, hi_exp);
    check({tag, " lo"}, lo_o, lo_exp);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    check("reset hi", hi_o, 0);
    check("reset lo", lo_o, 0);
    rst = 1'b0;
    @(negedge clk);
    do_op("mult -3*7", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 34);
    check("mult -3*7 busy cycles", busy_cnt, 33);
    @(negedge clk);
    check("done one cycle", done_o, 0);
    do_op("multu max*max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
    do_op("mult -1*-1", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 34);
    do_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    do_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    do_op("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34);
    do_op("div min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34);
    do_op("div -5/0", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 2);
    do_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 2);
    check("divu 5/0 busy cycles", busy_cnt, 1);
    launch(MULTU, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    check("cancel busy", busy_o, 0);
    start_i = 1'b1;
    @(negedge clk);
    check("start with cancel busy", busy_o, 0);
    start_i = 1'b0;
    cancel_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      done_cnt += int'(done_o);
      @(negedge clk);
    end
    check("cancel no done", done_cnt, 0);
    check("cancel hi held", hi_o, 32'd5);
    check("cancel lo held", lo_o, 32'hFFFFFFFF);
    do_op("restart 3*4", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 34);
    launch(MULTU, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    launch(DIVU, 32'd100, 32'd7);
    wait_done("busy start", lat, busy_cnt);
    check("busy start latency", lat, 30);
    check("busy start hi", hi_o, 32'd0);
    check("busy start lo", lo_o, 32'd42);
    @(negedge clk);
    launch(MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset busy", busy_o, 0);
    check("mid reset done", done_o, 0);
    check("mid reset hi", hi_o, 0);
    check("mid reset lo", lo_o, 0);
    rst = 1'b0;
    do_op("post reset divu 1000/9", DIVU, 32'd1000, 32'd9, 32'd1, 32'd111, 34);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
